// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative mul/div unit.
// The master drives requests and MTHI/MTLO writes; the slave returns status and HI/LO.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; one result bit per cycle,
// operating on magnitudes with the recorded signs applied in a final fix-up cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_q, sign_d;
  logic             rsign_q, rsign_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Multiply step: add multiplicand into the upper half, shift the pair right.
  logic [WIDTH:0]   mul_sum;
  // Divide step: restoring shift-subtract on a WIDTH+1 bit partial remainder.
  logic [WIDTH:0]   div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic             signed_op, a_neg, b_neg;

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod      = {work_hi_q, work_lo_q};
    prod_neg  = -prod;
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sign_d    = sign_q;
    rsign_d   = rsign_q;
    divz_d    = divz_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          work_hi_d = '0;
          work_lo_d = a_neg ? -bus.a : bus.a;
          opb_d     = b_neg ? -bus.b : bus.b;
          cnt_d     = '0;
          is_div_d  = bus.op[1];
          sign_d    = a_neg ^ b_neg;
          rsign_d   = a_neg;
          divz_d    = (bus.b == '0);
          state_d   = S_CALC;
        end else if (!bus.start) begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              work_hi_d = div_diff[WIDTH-1:0];
              work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              work_hi_d = div_shift[WIDTH-1:0];
              work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            work_hi_d = mul_sum[WIDTH:1];
            work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero falls out as remainder = |a|; only the quotient is forced.
            lo_d = divz_q ? '1 : (sign_q ? -work_lo_q : work_lo_q);
            hi_d = rsign_q ? -work_hi_q : work_hi_q;
          end else begin
            {hi_d, lo_d} = sign_q ? prod_neg : prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sign_q    <= 1'b0;
      rsign_q   <= 1'b0;
      divz_q    <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sign_q    <= sign_d;
      rsign_q   <= rsign_d;
      divz_q    <= divz_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table through a result scoreboard,
// plus hand-written MTHI/MTLO, flush and asynchronous reset sequences.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  hi;
    logic [31:0]  lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   overlap = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (bus.busy && bus.done) overlap++;
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    res_t r;
    int   n;
    bit   seen;
    @(negedge clk);
    bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.start = 1'b1;
    r.hi = v.hi; r.lo = v.lo;
    sb_q.push_back(r);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1;
    end
    chk({tag, "_latency"}, n, 33);
    if (seen && sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk({tag, "_hi"}, bus.hi, r.hi);
      chk({tag, "_lo"}, bus.lo, r.lo);
      chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL %s_done: no result within 40 cycles, expected done", tag);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d, input logic fl);
    @(negedge clk);
    bus.hi_we = hw; bus.lo_we = lw; bus.wdata = d; bus.flush = fl;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7]  = '{2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);

    // MTHI/MTLO preload, then an operation aborted by flush
    mt_write(1'b1, 1'b0, 32'hAAAA0000, 1'b0);
    chk("mthi", bus.hi, 32'hAAAA0000);
    mt_write(1'b0, 1'b1, 32'h00005555, 1'b0);
    chk("mtlo", bus.lo, 32'h00005555);
    chk("mtlo_hi_kept", bus.hi, 32'hAAAA0000);
    done_cnt = 0;
    @(negedge clk);
    bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.hi_we = 1'b1; bus.wdata = 32'h11111111;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("busy_hi_we_dropped", bus.hi, 32'hAAAA0000);
    chk("busy_mid", 32'(bus.busy), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", done_cnt, 0);
    chk("flush_hi", bus.hi, 32'hAAAA0000);
    chk("flush_lo", bus.lo, 32'h00005555);

    // flush and start together in IDLE: nothing accepted, and start drops hi_we
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'h22222222;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.hi_we = 1'b0;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    chk("flush_start_hi", bus.hi, 32'hAAAA0000);
    mt_write(1'b1, 1'b1, 32'h0000CAFE, 1'b1);
    chk("mt_both_hi", bus.hi, 32'h0000CAFE);
    chk("mt_both_lo", bus.lo, 32'h0000CAFE);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_op(v, $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.op = 2'b11; bus.a = 32'h1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(negedge clk); rst = 1'b0;
    v = '{2'b11, 32'd9, 32'd3, 32'd0, 32'd3};
    run_op(v, "post_rst");

    chk("busy_done_overlap", overlap, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative 32-bit multiply/divide unit for the EX stage, alongside the alu. It executes MULT, MULTU, DIV and DIVU, writing the architectural HI/LO pair. MTHI/MTLO write HI/LO directly. The busy output stalls the pipeline hazard logic. HI/LO feed the EX-stage result mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; latency scales as WIDTH+1 cycles.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request a new operation; sampled only in IDLE.
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
a  input  WIDTH  rs operand: multiplicand or dividend.
b  input  WIDTH  rt operand: multiplier or divisor.
flush  input  1  abort the in-flight operation (branch/exception squash).
hi_we  input  1  MTHI write strobe.
lo_we  input  1  MTLO write strobe.
wdata  input  WIDTH  MTHI/MTLO data.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse when HI/LO receive a result.
hi  output  WIDTH  HI register: product high word or remainder.
lo  output  WIDTH  LO register: product low word or quotient.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal operand registers=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at edge k: latch op and the operand magnitudes (absolute value for signed ops); record result signs.
  - Sign rules: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Counter is cleared and the FSM enters CALC. busy=1 from edge k.
- CALC, edges k+1..k+WIDTH, one bit per cycle:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits wide.
  - Counter increments each cycle. Leave CALC when counter reaches WIDTH-1 at an edge.
- FIX, edge k+WIDTH+1:
  - Two's-complement negate each result field whose recorded sign is 1.
  - Write hi/lo, state=IDLE, busy=0, done=1.
  - done clears at the next edge.
  - Result is visible 33 cycles after the accepting edge (WIDTH=32).
- Divide by zero (b=0), same latency: lo=all ones, hi=a (original dividend, unsigned and signed). No exception.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no flag).
- MULT and MULTU differ only in operand sign handling; results are exact 64-bit products.
- start while busy=1 is ignored (no queueing). The pipeline must hold the instruction until busy=0.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; registers update at that edge.
  - hi_we and lo_we may both be asserted, writing both.
  - Dropped while busy=1, and dropped when start=1 on the same edge (start wins).
- flush=1 while busy (CALC or FIX): next edge returns to IDLE with busy=0 and done=0; hi/lo keep their pre-operation values.
- flush in IDLE: no effect. flush and start on the same IDLE edge: flush wins, nothing is accepted.
- done is never asserted without an hi/lo update; busy and done are never both 1.
- hi/lo change only on a FIX edge, an accepted hi_we/lo_we edge, or reset.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> busy 1 for 33 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00001234, done=1.
- Preload via MTHI=0xAAAA0000, MTLO=0x5555; start MULT; pulse hi_we and a second start at cycle 5; flush at cycle 10 -> busy=0 next edge, done never pulses, hi/lo still 0xAAAA0000/0x5555.
- Assert rst asynchronously mid-CALC (between clock edges) -> busy, done, hi, lo go to 0 immediately. After release, a DIVU 9/3 completes with lo=3, hi=0.
